// File: rtl/refclk_gte3_monitor.sv
// refclk_gte3_monitor
//   Companion for the GT differential refclk input buffer. It drives the active-low
//   CEB enable and waits a fixed settle time after powering the buffer up. It then
//   counts ODIV2 rising edges, which arrive asynchronously to the CLK domain, over
//   back-to-back windows. Each window count is flagged if it is out of range, and
//   LOCKED asserts after enough consecutive good windows.
//   Optional build macro: REFCLK_MON_STICKY_ERR_EN makes FREQ_ERR sticky. Once set,
//   it is cleared only by reset or by ENABLE=0.
module refclk_gte3_monitor #(
  parameter int CEB_HOLD_CYCLES = 64,
  parameter int WINDOW_CYCLES   = 1024,
  parameter int EXP_MIN         = 200,
  parameter int EXP_MAX         = 312,
  parameter int LOCK_WINDOWS    = 4,
  parameter int CNT_W           = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_odiv2,
  output logic             o_ceb,
  output logic             o_locked,
  output logic             o_freq_err,
  output logic             o_count_valid,
  output logic [CNT_W-1:0] o_edge_count
);

  localparam int SET_W  = $clog2(CEB_HOLD_CYCLES + 1);
  localparam int WIN_W  = $clog2(WINDOW_CYCLES);
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(CEB_HOLD_CYCLES - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_WINDOWS);
  localparam logic [31:0]       LIM_MIN  = EXP_MIN;
  localparam logic [31:0]       LIM_MAX  = EXP_MAX;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_odiv2_p0, r_odiv2_p1, r_odiv2_hist_p2;
  logic [SET_W-1:0]   r_set_cnt;
  logic [WIN_W-1:0]   r_win_cnt;
  logic [CNT_W-1:0]   r_edge_cnt;
  logic [GOOD_W-1:0]  r_good_cnt;
  logic               w_rise, w_settle_done, w_terminal, w_in_range;
  logic [CNT_W-1:0]   w_final;
  logic [GOOD_W-1:0]  w_good_nxt;

  // Edge count increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  assign w_rise        = r_odiv2_p1 & ~r_odiv2_hist_p2;
  assign w_settle_done = (r_state == S_SETTLE) && (r_set_cnt == SET_LAST);
  assign w_terminal    = (r_state == S_MEASURE) && (r_win_cnt == WIN_LAST) && i_enable;
  assign w_final       = sat_inc(r_edge_cnt, w_rise);
  assign w_in_range    = (32'(w_final) >= LIM_MIN) && (32'(w_final) <= LIM_MAX);
  assign w_good_nxt    = (r_good_cnt == GOOD_MAX) ? r_good_cnt : r_good_cnt + GOOD_W'(1);

  // ODIV2 two-flop synchroniser plus history flop for rising-edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_odiv2_p0      <= 1'b0;
      r_odiv2_p1      <= 1'b0;
      r_odiv2_hist_p2 <= 1'b0;
    end else begin
      r_odiv2_p0      <= i_odiv2;
      r_odiv2_p1      <= r_odiv2_p0;
      r_odiv2_hist_p2 <= r_odiv2_p1;
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: dropping ENABLE always returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_SETTLE;
        S_SETTLE:  if (w_settle_done) w_state_nxt = S_MEASURE;
        S_MEASURE: w_state_nxt = S_MEASURE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Settle, window and edge counters. The terminal rise goes into w_final, and the counter restarts at zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_set_cnt  <= '0;
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
    end else if (!i_enable || (r_state == S_IDLE)) begin
      r_set_cnt  <= '0;
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
    end else if (r_state == S_SETTLE) begin
      r_set_cnt  <= w_settle_done ? '0 : r_set_cnt + SET_W'(1);
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_set_cnt  <= '0;
      r_win_cnt  <= w_terminal ? '0 : r_win_cnt + WIN_W'(1);
      r_edge_cnt <= w_terminal ? '0 : w_final;
    end
  end

  // Buffer enable, window result and lock tracking
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ceb         <= 1'b1;
      o_locked      <= 1'b0;
      o_freq_err    <= 1'b0;
      o_count_valid <= 1'b0;
      o_edge_count  <= '0;
      r_good_cnt    <= '0;
    end else begin
      o_count_valid <= w_terminal;
      if (!i_enable) begin
        o_ceb      <= 1'b1;
        o_locked   <= 1'b0;
        r_good_cnt <= '0;
`ifdef REFCLK_MON_STICKY_ERR_EN
        o_freq_err <= 1'b0;
`endif
      end else begin
        o_ceb <= 1'b0;
        if (w_terminal) begin
          o_edge_count <= w_final;
`ifdef REFCLK_MON_STICKY_ERR_EN
          o_freq_err   <= o_freq_err | ~w_in_range;
`else
          o_freq_err   <= ~w_in_range;
`endif
          if (w_in_range) begin
            r_good_cnt <= w_good_nxt;
            o_locked   <= (w_good_nxt == GOOD_MAX);
          end else begin
            r_good_cnt <= '0;
            o_locked   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_refclk_gte3_monitor.sv
// Testbench for refclk_gte3_monitor. It runs two instances on shared stimulus:
// one uses a 16-bit counter and one uses a 4-bit counter that saturates.
// The reference model records the clock edge at which each ODIV2 rise was driven.
// Each window's count is derived from the settle/window timing and the 3-cycle detection latency.
module tb_refclk_gte3_monitor;
  localparam int HOLD  = 8;
  localparam int WIN   = 100;
  localparam int EMIN  = 20;
  localparam int EMAX  = 30;
  localparam int LOCKW = 2;

  logic        clk = 1'b0;
  logic        rst, en, od;
  logic        ceb0, lk0, fe0, cv0;
  logic [15:0] ec0;
  logic        ceb1, lk1, fe1, cv1;
  logic [3:0]  ec1;

  refclk_gte3_monitor #(.CEB_HOLD_CYCLES(HOLD), .WINDOW_CYCLES(WIN), .EXP_MIN(EMIN),
                        .EXP_MAX(EMAX), .LOCK_WINDOWS(LOCKW), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_odiv2(od),
    .o_ceb(ceb0), .o_locked(lk0), .o_freq_err(fe0), .o_count_valid(cv0), .o_edge_count(ec0));

  refclk_gte3_monitor #(.CEB_HOLD_CYCLES(HOLD), .WINDOW_CYCLES(WIN), .EXP_MIN(EMIN),
                        .EXP_MAX(EMAX), .LOCK_WINDOWS(LOCKW), .CNT_W(4)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_odiv2(od),
    .o_ceb(ceb1), .o_locked(lk1), .o_freq_err(fe1), .o_count_valid(cv1), .o_edge_count(ec1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rises[$];
  bit m_on;
  int m_e;
  bit e_cv;
  int e_cnt[2];
  bit e_err[2];
  int e_good[2];
  bit e_lock[2];
  int maxv[2] = '{65535, 15};
  int od_hi = 2, od_lo = 2, od_cnt = 0;
  bit od_run = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 1'b0;
    e_cv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_cnt[i] = 0; e_err[i] = 1'b0; e_good[i] = 0; e_lock[i] = 1'b0;
    end
  endtask

  // Rises whose detection edge (drive edge + 3) lies in the window ending at edge n
  function automatic int window_raw(input int n);
    int c = 0;
    foreach (rises[i]) if ((rises[i] + 3 >= n - WIN + 1) && (rises[i] + 3 <= n)) c++;
    return c;
  endfunction

  task automatic model_edge(input int n, input logic en_s);
    int raw, c;
    bit oor;
    if (!en_s) begin
      m_on = 1'b0;
      e_cv = 1'b0;
      for (int i = 0; i < 2; i++) begin
        e_good[i] = 0; e_lock[i] = 1'b0;
`ifdef REFCLK_MON_STICKY_ERR_EN
        e_err[i] = 1'b0;
`endif
      end
    end else begin
      if (!m_on) begin m_on = 1'b1; m_e = n; end
      e_cv = (n >= m_e + HOLD + WIN) && (((n - m_e - HOLD - WIN) % WIN) == 0);
      if (e_cv) begin
        raw = window_raw(n);
        for (int i = 0; i < 2; i++) begin
          c = (raw > maxv[i]) ? maxv[i] : raw;
          e_cnt[i] = c;
          oor = (c < EMIN) || (c > EMAX);
`ifdef REFCLK_MON_STICKY_ERR_EN
          e_err[i] = e_err[i] | oor;
`else
          e_err[i] = oor;
`endif
          if (oor) e_good[i] = 0;
          else if (e_good[i] < LOCKW) e_good[i]++;
          e_lock[i] = (e_good[i] >= LOCKW);
        end
      end
    end
  endtask

  task automatic check_all();
    chk1("ceb",       ceb0, !m_on);
    chk1("cnt_valid", cv0,  e_cv);
    chkv("edge_cnt",  32'(ec0), e_cnt[0]);
    chk1("freq_err",  fe0,  e_err[0]);
    chk1("locked",    lk0,  e_lock[0]);
    chk1("sat_ceb",   ceb1, !m_on);
    chk1("sat_valid", cv1,  e_cv);
    chkv("sat_cnt",   32'(ec1), e_cnt[1]);
    chk1("sat_err",   fe1,  e_err[1]);
    chk1("sat_lock",  lk1,  e_lock[1]);
  endtask

  task automatic set_od(input bit run, input int hi, input int lo);
    od_run = run; od_hi = hi; od_lo = lo; od_cnt = 0;
  endtask

  task automatic tick();
    logic en_s, nv;
    en_s = en;
    @(posedge clk);
    cyc++;
    #1;
    model_edge(cyc, en_s);
    check_all();
    nv = od;
    if (!od_run) nv = 1'b0;
    else begin
      od_cnt++;
      if (od && od_cnt >= od_hi) begin nv = 1'b0; od_cnt = 0; end
      else if (!od && od_cnt >= od_lo) begin nv = 1'b1; od_cnt = 0; end
    end
    if (nv && !od) rises.push_back(cyc);
    od = nv;
  endtask

  // Asynchronous reset pulse asserted between clock edges
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; od = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1 rst = 1'b0;
    repeat (3) tick();

    // Nominal period 4: 25 edges per window, lock on second window
    set_od(1, 2, 2); en = 1'b1;
    repeat (HOLD + 3 * WIN + 5) tick();
    // Slow refclk: out of range, lock drops, then relock
    set_od(1, 4, 4);
    repeat (WIN) tick();
    set_od(1, 2, 2);
    repeat (2 * WIN + 20) tick();
    // Dead refclk
    set_od(0, 2, 2);
    repeat (2 * WIN) tick();
    // Random duty/period per window
    for (int k = 0; k < 8; k++) begin
      set_od(1, int'($urandom_range(2, 5)), int'($urandom_range(2, 5)));
      repeat (WIN) tick();
    end
    // Enable drop mid-window and full re-settle
    set_od(1, 2, 2);
    repeat (150) tick();
    repeat (int'($urandom_range(10, 60))) tick();
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    repeat (HOLD + 2 * WIN + 10) tick();
    // Reset mid-measure with refclk quiet, then restart
    repeat (37) tick();
    set_od(0, 2, 2);
    repeat (5) tick();
    do_reset();
    set_od(1, 2, 2);
    repeat (HOLD + 3 * WIN + 10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
